// File: rtl/pkt_sched.sv
// pkt_sched: per-channel periodic packet-request generator with round-robin valid/ready arbitration
// Ports: clk; rst (sync, active-high); ch_en[NUM_CH] channel enables;
//   period[NUM_CH*CNT_W] per-channel period, channel i at [i*CNT_W +: CNT_W];
//   req_valid/req_ch/req_ready request handshake; led toggles per accepted request;
//   miss_cnt saturating overrun count when PKT_SCHED_MISS_CNT_EN is defined, otherwise tied to 0.
module pkt_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 24,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*CNT_W-1:0] period,
  output logic                    req_valid,
  output logic [CH_W-1:0]         req_ch,
  input  logic                    req_ready,
  output logic                    led,
  output logic [15:0]             miss_cnt
);
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] tick, pend, clr;
  logic [CH_W-1:0]   base, gnt, idx;
  logic              found, sel;
  int                j;

  // period 0 compares as period 1 (0 - 1 would wrap), so it ticks every enabled cycle
  always_comb begin
    tick = '0;
    for (int i = 0; i < NUM_CH; i++)
      tick[i] = ch_en[i] && (period[i*CNT_W +: CNT_W] == '0 || cnt[i] >= period[i*CNT_W +: CNT_W] - 1'b1);
  end

  // scan from the farthest candidate down so the nearest pending channel after base wins
  always_comb begin
    found = 1'b0;
    gnt = '0;
    j = 0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = int'(base) + k;
      j = j >= NUM_CH ? j - NUM_CH : j;
      idx = CH_W'(j);
      if (pend[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end

  assign sel = found && (!req_valid || req_ready);
  assign clr = sel ? NUM_CH'(1) << gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      pend <= '0;
      req_valid <= 1'b0;
      req_ch <= '0;
      base <= '0;
      led <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= (ch_en[i] && !tick[i]) ? cnt[i] + 1'b1 : '0;
      // a tick landing on the edge that clears the same channel re-arms it
      pend <= ch_en & ((pend & ~clr) | tick);
      if (sel) begin
        req_valid <= 1'b1;
        req_ch <= gnt;
        base <= gnt == CH_W'(NUM_CH - 1) ? '0 : gnt + 1'b1;
      end else if (req_ready) begin
        req_valid <= 1'b0;
      end
      if (req_valid && req_ready) led <= ~led;
    end
  end

`ifdef PKT_SCHED_MISS_CNT_EN
  logic [NUM_CH-1:0] ovr;
  logic [16:0]       miss_sum;
  logic [15:0]       miss_q;
  assign ovr = tick & pend & ~clr;
  always_comb begin
    miss_sum = {1'b0, miss_q};
    for (int i = 0; i < NUM_CH; i++) miss_sum = miss_sum + 17'(ovr[i]);
  end
  always_ff @(posedge clk) miss_q <= rst ? '0 : miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
  assign miss_cnt = miss_q;
`else
  assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_sched.sv
// tb_pkt_sched: directed tables, corner sequences and randomized model comparison for pkt_sched
module tb_pkt_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ch_en = '0;
  logic [95:0] period = '0;
  logic        req_valid;
  logic [1:0]  req_ch;
  logic        req_ready = 1'b0;
  logic        led;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon = 0;

  int age [4];
  bit mp [4];
  bit mv;
  int mch, mlast, mmiss;
  bit mled;

  typedef struct {
    logic [3:0] en;
    int p0, p1, p2, p3;
    bit rdy;
    int n;
    bit ev;
    int ech;
    bit eled;
  } vec_t;

  vec_t tbl [10];

  pkt_sched dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .period(period),
    .req_valid(req_valid), .req_ch(req_ch), .req_ready(req_ready),
    .led(led), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic set_per(input int i, input int v);
    period[i*24 +: 24] = v[23:0];
  endtask

  // reference: each channel ages since enable/last tick; fires when age+1 reaches max(period,1)
  task automatic model_step();
    bit tk [4];
    bit nxt [4];
    bit sel, acc, cl;
    int g, c, p, ov;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin age[i] = 0; mp[i] = 0; end
      mv = 0; mch = 0; mlast = 3; mled = 1; mmiss = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      p = int'(period[i*24 +: 24]);
      if (p == 0) p = 1;
      tk[i] = ch_en[i] && (age[i] + 1 >= p);
    end
    sel = 0; g = 0;
    if (!mv || req_ready)
      for (int k = 0; k < 4; k++) begin
        c = (mlast + 1 + k) % 4;
        if (!sel && mp[c]) begin sel = 1; g = c; end
      end
    acc = mv && req_ready;
    ov = 0;
    for (int i = 0; i < 4; i++) begin
      cl = sel && g == i;
      if (tk[i] && mp[i] && !cl) ov++;
      nxt[i] = ch_en[i] && ((mp[i] && !cl) || tk[i]);
      age[i] = (ch_en[i] && !tk[i]) ? age[i] + 1 : 0;
    end
    for (int i = 0; i < 4; i++) mp[i] = nxt[i];
    if (acc) mled = !mled;
    if (sel) begin mv = 1; mch = g; mlast = g; end
    else if (acc) mv = 0;
`ifdef PKT_SCHED_MISS_CNT_EN
    mmiss = mmiss + ov > 65535 ? 65535 : mmiss + ov;
`endif
  endtask

  task automatic tick_cycle();
    if (mon) begin
      chk("mdl_valid", int'(req_valid), int'(mv));
      chk("mdl_ch", int'(req_ch), mch);
      chk("mdl_led", int'(led), int'(mled));
      chk("mdl_miss", int'(miss_cnt), mmiss);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      ch_en = 4'($urandom);
      period = {$urandom, $urandom, $urandom};
      req_ready = 1'($urandom);
      tick_cycle();
    end
    chk("rst_valid", int'(req_valid), 0);
    chk("rst_ch", int'(req_ch), 0);
    chk("rst_led", int'(led), 1);
    chk("rst_miss", int'(miss_cnt), 0);
    rst = 0; ch_en = '0; period = '0; req_ready = 0; cyc = 0;
  endtask

  initial begin
    int n, exp_miss;
    bit ev;
    tbl[0] = '{4'b0000, 0, 0, 0, 0, 1'b1, 5, 1'b0, 0, 1'b1};
    tbl[1] = '{4'b0001, 10, 0, 0, 0, 1'b1, 11, 1'b1, 0, 1'b1};
    tbl[2] = '{4'b0001, 10, 0, 0, 0, 1'b1, 12, 1'b0, 0, 1'b0};
    tbl[3] = '{4'b0010, 0, 5, 0, 0, 1'b0, 6, 1'b1, 1, 1'b1};
    tbl[4] = '{4'b0100, 0, 0, 0, 0, 1'b1, 2, 1'b1, 2, 1'b1};
    tbl[5] = '{4'b0100, 0, 0, 0, 0, 1'b1, 3, 1'b1, 2, 1'b0};
    tbl[6] = '{4'b1000, 0, 0, 0, 1, 1'b0, 10, 1'b1, 3, 1'b1};
    tbl[7] = '{4'b1100, 0, 0, 3, 3, 1'b1, 4, 1'b1, 2, 1'b1};
    tbl[8] = '{4'b1100, 0, 0, 3, 3, 1'b1, 5, 1'b1, 3, 1'b0};
    tbl[9] = '{4'b1111, 4, 4, 4, 4, 1'b1, 7, 1'b1, 2, 1'b1};

    do_reset();
    mon = 1;

    foreach (tbl[t]) begin
      do_reset();
      ch_en = tbl[t].en;
      set_per(0, tbl[t].p0); set_per(1, tbl[t].p1); set_per(2, tbl[t].p2); set_per(3, tbl[t].p3);
      req_ready = tbl[t].rdy;
      for (int c = 0; c < tbl[t].n; c++) tick_cycle();
      chk($sformatf("tbl%0d_valid", t), int'(req_valid), int'(tbl[t].ev));
      if (tbl[t].ev) chk($sformatf("tbl%0d_ch", t), int'(req_ch), tbl[t].ech);
      chk($sformatf("tbl%0d_led", t), int'(led), int'(tbl[t].eled));
    end

    do_reset();
    ch_en = 4'b0001; set_per(0, 10); req_ready = 1;
    for (int c = 0; c <= 40; c++) begin
      ev = c >= 11 && c % 10 == 1;
      chk("p10_valid", int'(req_valid), int'(ev));
      if (ev) chk("p10_ch", int'(req_ch), 0);
      n = c >= 12 ? (c - 12) / 10 + 1 : 0;
      chk("p10_led", int'(led), 1 ^ (n & 1));
      tick_cycle();
    end

    do_reset();
    ch_en = 4'b1111; for (int i = 0; i < 4; i++) set_per(i, 4); req_ready = 1;
    for (int c = 0; c <= 40; c++) begin
      chk("rr_valid", int'(req_valid), int'(c >= 5));
      if (c >= 5) chk("rr_ch", int'(req_ch), (c - 5) % 4);
      chk("rr_miss", int'(miss_cnt), 0);
      tick_cycle();
    end

    do_reset();
    ch_en = 4'b0010; set_per(1, 5); req_ready = 0;
    for (int c = 0; c < 20; c++) begin
      chk("stall_valid", int'(req_valid), int'(c >= 6));
      if (c >= 6) chk("stall_ch", int'(req_ch), 1);
      tick_cycle();
    end
    exp_miss = 0;
`ifdef PKT_SCHED_MISS_CNT_EN
    exp_miss = 2;
`endif
    chk("stall_miss", int'(miss_cnt), exp_miss);
    chk("stall_hold", int'(req_valid), 1);

    do_reset();
    ch_en = 4'b0001; set_per(0, 100); req_ready = 1;
    for (int c = 0; c <= 95; c++) begin
      if (c == 50) set_per(0, 20);
      chk("shrink_valid", int'(req_valid), int'(c == 52 || c == 72 || c == 92));
      tick_cycle();
    end

    do_reset();
    ch_en = 4'b1111; for (int i = 0; i < 4; i++) set_per(i, 3); req_ready = 0;
    for (int c = 0; c < 7; c++) tick_cycle();
    chk("mid_valid", int'(req_valid), 1);
    chk("mid_ch", int'(req_ch), 0);
    rst = 1;
    tick_cycle();
    chk("mid_rst_valid", int'(req_valid), 0);
    chk("mid_rst_led", int'(led), 1);
    rst = 0; ch_en = 4'b0011; set_per(0, 2); set_per(1, 2); req_ready = 1; cyc = 0;
    for (int c = 0; c <= 4; c++) begin
      if (c == 3) begin chk("post_valid0", int'(req_valid), 1); chk("post_ch0", int'(req_ch), 0); end
      if (c == 4) begin chk("post_valid1", int'(req_valid), 1); chk("post_ch1", int'(req_ch), 1); end
      tick_cycle();
    end

    do_reset();
    for (int i = 0; i < 4; i++) set_per(i, $urandom_range(0, 6));
    ch_en = 4'($urandom);
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 399) == 0;
      req_ready = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) set_per($urandom_range(0, 3), $urandom_range(0, 6));
      tick_cycle();
    end
    rst = 0;
    tick_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
